// File: rtl/pool_pkg.sv
// Shared FSM encoding and default geometry for the 2x2 max-pool / ReLU stage.
package pool_pkg;

  localparam int unsigned DEF_IFM_SIZE = 28;
  localparam int unsigned OFM_DEPTH    = DEF_IFM_SIZE * DEF_IFM_SIZE;
  localparam int unsigned POOL_SIDE    = DEF_IFM_SIZE / 2;
  localparam int unsigned OFM_ADDR_W   = $clog2(OFM_DEPTH);
  localparam int unsigned POOL_ADDR_W  = $clog2(POOL_SIDE * POOL_SIDE);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    OUT,
    FIN
  } pool_state_e;

  // Counter width that never collapses to zero bits for a 1x1 pooled map.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// OFM address of one sample of a 2x2 window: idx[0] selects the column, idx[1] the row.
module pool_addr_gen #(
  parameter int unsigned IFM_SIZE = 28,
  parameter int unsigned RC_W     = 4,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic [RC_W-1:0]   row,
  input  logic [RC_W-1:0]   col,
  input  logic [1:0]        idx,
  output logic [ADDR_W-1:0] addr_c
);

  logic [31:0] base;

  always_comb begin
    base   = 32'(row) * 32'(2 * IFM_SIZE) + 32'(col) * 32'd2;
    addr_c = ADDR_W'(base + 32'(idx[0]) + (idx[1] ? 32'(IFM_SIZE) : 32'd0));
  end

endmodule

// File: rtl/maxpool_relu_stage.sv
// Streams 2x2 windows out of the OFM SRAM and emits their signed maximum.
// Define MAXPOOL_RELU_EN to clamp negative maxima to zero (ReLU); timing is unchanged.
module maxpool_relu_stage
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IFM_SIZE   = DEF_IFM_SIZE
) (
  input  logic                                               HCLK,
  input  logic                                               HRESET,
  input  logic                                               start,
  output logic                                               ofm_rd_en,
  output logic [$clog2(IFM_SIZE*IFM_SIZE)-1:0]               ofm_rd_addr,
  input  logic signed [DATA_WIDTH-1:0]                       ofm_rd_data,
  output logic                                               pool_valid,
  input  logic                                               pool_ready,
  output logic signed [DATA_WIDTH-1:0]                       pool_data,
  output logic [$clog2((IFM_SIZE/2)*(IFM_SIZE/2))-1:0]       pool_addr,
  output logic                                               busy,
  output logic                                               done
);

  localparam int unsigned HALF    = IFM_SIZE / 2;
  localparam int unsigned OFM_AW  = $clog2(IFM_SIZE * IFM_SIZE);
  localparam int unsigned POOL_AW = $clog2(HALF * HALF);
  localparam int unsigned RC_W    = min1_clog2(HALF);
  localparam logic [RC_W-1:0] LAST_RC = RC_W'(HALF - 1);

  pool_state_e state_q, state_d;
  logic [RC_W-1:0]              row_q, row_d, col_q, col_d;
  logic [1:0]                   rd_idx_q, rd_idx_d;
  logic [1:0]                   cap_idx_q, cap_idx_d;
  logic                         rd_vld_q;
  logic signed [DATA_WIDTH-1:0] max_q, max_d, cap_val_c, result_c;
  logic                         rd_en_d, pool_valid_d, busy_d, done_d;
  logic [OFM_AW-1:0]            rd_addr_d, gen_addr_c;
  logic signed [DATA_WIDTH-1:0] pool_data_d;
  logic [POOL_AW-1:0]           pool_addr_d;

  // Address of the read about to be issued, so the registered address lines up with rd_en.
  pool_addr_gen #(
    .IFM_SIZE (IFM_SIZE),
    .RC_W     (RC_W),
    .ADDR_W   (OFM_AW)
  ) u_addr_gen (
    .row    (row_d),
    .col    (col_d),
    .idx    (rd_idx_d),
    .addr_c (gen_addr_c)
  );

  always_comb begin
    rd_addr_d = rd_en_d ? gen_addr_c : '0;
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    rd_idx_d     = rd_idx_q;
    cap_idx_d    = cap_idx_q;
    max_d        = max_q;
    rd_en_d      = 1'b0;
    pool_valid_d = pool_valid;
    pool_data_d  = pool_data;
    pool_addr_d  = pool_addr;
    busy_d       = busy;
    done_d       = 1'b0;

    // Read data trails rd_en by one cycle; the first sample of a window loads unconditionally.
    cap_val_c = (cap_idx_q == 2'd0 || ofm_rd_data > max_q) ? ofm_rd_data : max_q;
    if (rd_vld_q) begin
      max_d     = cap_val_c;
      cap_idx_d = cap_idx_q + 2'd1;
    end

`ifdef MAXPOOL_RELU_EN
    result_c = cap_val_c[DATA_WIDTH-1] ? '0 : cap_val_c;
`else
    result_c = cap_val_c;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          row_d    = '0;
          col_d    = '0;
          rd_idx_d = '0;
          rd_en_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        if (rd_idx_q == 2'd3) begin
          rd_idx_d = '0;
          state_d  = DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + 2'd1;
          rd_en_d  = 1'b1;
        end
      end
      DRAIN: begin
        pool_valid_d = 1'b1;
        pool_data_d  = result_c;
        pool_addr_d  = POOL_AW'(32'(row_q) * 32'(HALF) + 32'(col_q));
        state_d      = OUT;
      end
      OUT: begin
        if (pool_ready) begin
          pool_valid_d = 1'b0;
          if (row_q == LAST_RC && col_q == LAST_RC) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            if (col_q == LAST_RC) begin
              col_d = '0;
              row_d = row_q + RC_W'(1);
            end else begin
              col_d = col_q + RC_W'(1);
            end
            rd_idx_d = '0;
            rd_en_d  = 1'b1;
            state_d  = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      rd_idx_q    <= '0;
      cap_idx_q   <= '0;
      rd_vld_q    <= 1'b0;
      max_q       <= '0;
      ofm_rd_en   <= 1'b0;
      ofm_rd_addr <= '0;
      pool_valid  <= 1'b0;
      pool_data   <= '0;
      pool_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rd_idx_q    <= rd_idx_d;
      cap_idx_q   <= cap_idx_d;
      rd_vld_q    <= ofm_rd_en;
      max_q       <= max_d;
      ofm_rd_en   <= rd_en_d;
      ofm_rd_addr <= rd_addr_d;
      pool_valid  <= pool_valid_d;
      pool_data   <= pool_data_d;
      pool_addr   <= pool_addr_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_maxpool_relu_stage.sv
// Scoreboard bench for maxpool_relu_stage with a one-cycle-latency OFM SRAM model.
module tb_maxpool_relu_stage;

  localparam int unsigned IFM   = 28;
  localparam int unsigned HALF  = 14;
  localparam int unsigned DEPTH = 784;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              start = 1'b0;
  logic              pool_ready = 1'b1;
  logic              ofm_rd_en;
  logic [9:0]        ofm_rd_addr;
  logic signed [7:0] ofm_rd_data = '0;
  logic              pool_valid;
  logic signed [7:0] pool_data;
  logic [7:0]        pool_addr;
  logic              busy;
  logic              done;

  logic signed [7:0] mem [DEPTH];
  logic [15:0]       sb [$];
  int unsigned       rd_log [$];
  logic [15:0]       item;
  int                errors = 0;
  int                checks = 0;
  int                done_cnt = 0;
  int                res_cnt = 0;

  maxpool_relu_stage dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start       (start),
    .ofm_rd_en   (ofm_rd_en),
    .ofm_rd_addr (ofm_rd_addr),
    .ofm_rd_data (ofm_rd_data),
    .pool_valid  (pool_valid),
    .pool_ready  (pool_ready),
    .pool_data   (pool_data),
    .pool_addr   (pool_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (ofm_rd_en) ofm_rd_data <= mem[ofm_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] win_max(input int r, input int c);
    logic signed [7:0] m;
    int b;
    b = 2 * r * IFM + 2 * c;
    m = mem[b];
    if (mem[b + 1] > m) m = mem[b + 1];
    if (mem[b + IFM] > m) m = mem[b + IFM];
    if (mem[b + IFM + 1] > m) m = mem[b + IFM + 1];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic sb_fill();
    sb.delete();
    for (int r = 0; r < HALF; r++)
      for (int c = 0; c < HALF; c++)
        sb.push_back({8'(r * HALF + c), win_max(r, c)});
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!pool_valid && n < limit) begin
      tick();
      n++;
    end
    if (!pool_valid) check(tag, 32'(pool_valid), 1);
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      tick();
      n++;
    end
    if (done_cnt == base) check(tag, 32'(done_cnt), 32'(base + 1));
  endtask

  // Monitor: address hygiene, no reads while holding a result, scoreboard on handshakes.
  always @(negedge HCLK) begin
    if (ofm_rd_en) rd_log.push_back(32'(ofm_rd_addr));
    else check("rd_addr_idle", 32'(ofm_rd_addr), 0);
    if (pool_valid) check("no_read_while_valid", 32'(ofm_rd_en), 0);
    if (done) done_cnt++;
    if (pool_valid && pool_ready) begin
      res_cnt++;
      if (sb.size() == 0) begin
        check("sb_depth", 32'(sb.size()), 1);
      end else begin
        item = sb.pop_front();
        check("pool_addr", 32'(pool_addr), 32'(item[15:8]));
        check("pool_data", 32'($unsigned(pool_data)), 32'(item[7:0]));
      end
    end
  end

  initial begin
    int n;
    int done_base;
    int res_base;
    logic [7:0] exp_neg;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    // Reset held for three cycles
    HRESET = 1'b1;
    repeat (3) tick();
    check("rst_rd_en", 32'(ofm_rd_en), 0);
    check("rst_rd_addr", 32'(ofm_rd_addr), 0);
    check("rst_valid", 32'(pool_valid), 0);
    check("rst_data", 32'($unsigned(pool_data)), 0);
    check("rst_addr", 32'(pool_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    HRESET = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Full pass with a known first window and a stray start mid-pass
    mem[0] = 8'sd5; mem[1] = -8'sd3; mem[28] = 8'sd7; mem[29] = 8'sd2;
    sb_fill();
    rd_log.delete();
    done_base = done_cnt;
    res_base  = res_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("rd_en_first", 32'(ofm_rd_en), 1);
    n = 1;
    while (!pool_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_latency", 32'(n), 6);
    check("win0_data", 32'($unsigned(pool_data)), 7);
    check("win0_addr", 32'(pool_addr), 0);
    check("win0_nreads", 32'(rd_log.size()), 4);
    check("win0_rd0", rd_log[0], 0);
    check("win0_rd1", rd_log[1], 1);
    check("win0_rd2", rd_log[2], 28);
    check("win0_rd3", rd_log[3], 29);
    repeat (40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("pass1_done", done_base, 2000);
    repeat (3) tick();
    check("pass1_done_pulses", 32'(done_cnt - done_base), 1);
    check("pass1_results", 32'(res_cnt - res_base), 196);
    check("pass1_sb_empty", 32'(sb.size()), 0);
    check("pass1_busy_end", 32'(busy), 0);
    check("pass1_nreads", 32'(rd_log.size()), 784);
    check("last_rd0", rd_log[rd_log.size() - 4], 754);
    check("last_rd1", rd_log[rd_log.size() - 3], 755);
    check("last_rd2", rd_log[rd_log.size() - 2], 782);
    check("last_rd3", rd_log[rd_log.size() - 1], 783);

    // Negative window, then backpressure on window 5, then reset at window 40
    mem[0] = -8'sd5; mem[1] = -8'sd3; mem[28] = -8'sd7; mem[29] = -8'sd2;
    sb_fill();
    done_base = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("neg_valid", 20);
`ifdef MAXPOOL_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'hFE;
`endif
    check("neg_data", 32'($unsigned(pool_data)), 32'(exp_neg));

    n = 0;
    while (!(ofm_rd_en && ofm_rd_addr == 10'd10) && n < 100) begin
      tick();
      n++;
    end
    check("win5_read_start", 32'(ofm_rd_addr), 10);
    pool_ready = 1'b0;
    wait_valid("win5_valid", 20);
    check("bp_addr", 32'(pool_addr), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(pool_valid), 1);
      check("bp_data", 32'($unsigned(pool_data)), 32'(win_max(0, 5)));
      check("bp_addr_hold", 32'(pool_addr), 5);
      check("bp_no_read", 32'(ofm_rd_en), 0);
    end
    pool_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(pool_valid), 0);
    check("bp_next_rd_en", 32'(ofm_rd_en), 1);
    check("bp_next_rd_addr", 32'(ofm_rd_addr), 12);

    n = 0;
    while (!(pool_valid && pool_addr == 8'd40) && n < 400) begin
      tick();
      n++;
    end
    check("win40_reached", 32'(pool_addr), 40);
    HRESET = 1'b1;
    sb.delete();
    repeat (2) tick();
    check("abort_valid", 32'(pool_valid), 0);
    check("abort_busy", 32'(busy), 0);
    HRESET = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt - done_base), 0);

    // Restart after the aborted pass begins again at window 0
    sb_fill();
    res_base = res_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("restart_valid", 20);
    check("restart_addr", 32'(pool_addr), 0);
    check("restart_data", 32'($unsigned(pool_data)), 32'(win_max(0, 0)));
    wait_done("pass3_done", done_base, 2000);
    repeat (3) tick();
    check("pass3_done_pulses", 32'(done_cnt - done_base), 1);
    check("pass3_results", 32'(res_cnt - res_base), 196);
    check("pass3_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_stage.md
MAXPOOL_RELU_STAGE -- requirements
Module: maxpool_relu_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed width of OFM samples.
REQ-002 SHALL have parameter IFM_SIZE, default 28, OFM side length, which SHALL be even.
REQ-003 SHALL have port HCLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, one-cycle pulse that begins a pooling pass.
REQ-006 SHALL have port ofm_rd_en, output, 1 bit, OFM SRAM read strobe.
REQ-007 SHALL have port ofm_rd_addr, output, clog2(IFM_SIZE*IFM_SIZE) bits (10 at default), OFM read address.
REQ-008 SHALL have port ofm_rd_data, input, DATA_WIDTH bits, signed OFM read data, valid exactly 1 cycle after ofm_rd_en.
REQ-009 SHALL have port pool_valid, output, 1 bit, pooled result available.
REQ-010 SHALL have port pool_ready, input, 1 bit, consumer accepts the result.
REQ-011 SHALL have port pool_data, output, DATA_WIDTH bits, pooled signed result.
REQ-012 SHALL have port pool_addr, output, clog2((IFM_SIZE/2)^2) bits (8 at default), linear pooled index.
REQ-013 SHALL have port busy, output, 1 bit, high from the cycle after start is accepted until done.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse after the last result is accepted.

Function
REQ-015 SHALL implement an FSM with states IDLE, READ, DRAIN, OUT and FIN.
REQ-016 In IDLE, start SHALL clear the row and col counters to 0 and move to READ; start outside IDLE SHALL be ignored.
REQ-017 READ SHALL issue four consecutive reads, one per cycle, at base=(2*row)*IFM_SIZE+2*col, in the order base, base+1, base+IFM_SIZE, base+IFM_SIZE+1, then go to DRAIN.
REQ-018 DRAIN SHALL capture the 4th sample, register the signed maximum of the 4 samples into pool_data, set pool_valid, and go to OUT.
REQ-019 The running maximum SHALL be a signed compare, with the first sample loaded unconditionally.
REQ-020 In OUT, pool_data and pool_addr SHALL hold stable and no reads SHALL issue while pool_valid=1 and pool_ready=0.
REQ-021 A cycle with pool_valid=1 and pool_ready=1 SHALL complete the transfer. On that cycle the block SHALL advance col, wrapping to 0 and incrementing row at IFM_SIZE/2-1, and enter READ. If the window was the last (row=col=IFM_SIZE/2-1), it SHALL enter FIN instead.
REQ-022 pool_addr SHALL equal row*(IFM_SIZE/2)+col of the window presented.
REQ-023 Latency: with start sampled at edge k, ofm_rd_en SHALL be high on cycles k+1..k+4 and pool_valid SHALL first rise at k+6. With pool_ready held high, windows SHALL repeat every 6 cycles.
REQ-024 FIN SHALL pulse done for exactly 1 cycle, drop busy in the same cycle, and return to IDLE. A start in FIN SHALL be ignored.
REQ-025 ofm_rd_en SHALL be high only in READ; ofm_rd_addr SHALL be 0 whenever ofm_rd_en=0.

Reset
REQ-026 HRESET SHALL force IDLE, clear row, col and the maximum register, and drive ofm_rd_en, ofm_rd_addr, pool_valid, pool_data, pool_addr, busy and done to 0.
REQ-027 HRESET asserted mid-pass SHALL abort the pass with no done pulse; a later start SHALL restart at window 0.

Configuration
REQ-028 With macro MAXPOOL_RELU_EN defined, a negative maximum SHALL be clamped to 0 before being registered into pool_data.
REQ-029 Without MAXPOOL_RELU_EN, pool_data SHALL be the raw signed maximum; timing SHALL be identical in both cases.

Structure
REQ-030 Package pool_pkg SHALL hold the FSM state enum and the localparams OFM_DEPTH, POOL_SIDE, OFM_ADDR_W and POOL_ADDR_W.
REQ-031 Window address generation SHALL live in sub-module pool_addr_gen, which takes row, col and sample index and produces ofm_rd_addr; all other logic SHALL be flat.

Verification
REQ-032 Reset scenario: assert HRESET for 3 cycles with no start -> all outputs 0, busy=0.
REQ-033 Window scenario: window 0 holds {5,-3,7,2}, pool_ready=1 -> pool_data=7, pool_addr=0; pool_valid rises 6 cycles after start; read addresses are 0,1,28,29.
REQ-034 Negative scenario: window 0 holds {-5,-3,-7,-2} -> pool_data=0x00 with MAXPOOL_RELU_EN, 0xFE without it.
REQ-035 Backpressure scenario: hold pool_ready=0 for 3 cycles on window 5 -> pool_data and pool_addr=5 stable, no ofm_rd_en; transfer completes on the first ready cycle.
REQ-036 Full-pass scenario: 784-entry map, ready always high -> 196 results with pool_addr 0..195 in order, the last window read at 754,755,782,783, one done pulse, and a start during the pass ignored.
REQ-037 Mid-pass reset scenario: assert HRESET at window 40, then issue start -> no done for the aborted pass, and the next result has pool_addr=0.
